sst_reg_dumper: RTL and testbench

- Save-state register engine that drives the mapper save-state bus (sst_act, sst_addr, sst_we_reg, sst_dato) and consumes the mapper's sst_di readback.
- SAVE: walks register addresses 0..REG_COUNT-1 and streams one byte per address out on a valid/ready port.
- LOAD: takes a byte stream and writes each byte back into the mapper registers.
- Mapper registers latch on the falling edge of cpu.m2, so every write is held across a synchronized M2 falling edge.

---
 rtl/sst_reg_dumper.sv | 209 ++++++++++++++++++++
 tb/tb_sst_reg_dumper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sst_reg_dumper.sv
// Save-state register engine for the mapper save-state bus.
// SAVE walks register addresses 0..REG_COUNT-1 and streams one readback byte per address.
// LOAD writes a byte stream back into the mapper registers. Each write is held across a
// synchronized M2 fall. The last address holds the map_idx signature, which is compared
// against the final stream byte instead of being written.
module sst_reg_dumper #(
  parameter int unsigned REG_COUNT  = 128,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned M2_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready
);

  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned TmoW = $clog2(M2_TIMEOUT + 1);
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(M2_TIMEOUT - 1);
  // A 9-bit count keeps the last-address compare correct when REG_COUNT is 256.
  localparam logic [8:0] CntLast = 9'(REG_COUNT - 1);
  localparam logic [8:0] CntSig  = 9'(REG_COUNT - 2);
  localparam logic [7:0] SigAddr = 8'(REG_COUNT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRdSet,
    StRdWait,
    StRdPush,
    StLdGet,
    StLdArm,
    StLdHold,
    StLdSig,
    StLdSigWait,
    StFin
  } state_e;

  state_e          st_q;
  logic [8:0]      cnt_q;
  logic [LatW-1:0] lat_q;
  logic [TmoW-1:0] tmo_q;
  logic [7:0]      sig_q;
  logic            busy_q, done_q, err_q, sst_act_q, sst_we_q, dout_valid_q, din_ready_q;
  logic [7:0]      sst_addr_q, sst_dato_q, dout_q;

  logic [1:0] m2_sync_q;
  logic       m2_prev_q;
  logic       m2_fall;

  // Two-flop synchronizer for the raw M2 plus an edge register for fall detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_sync_q <= 2'b00;
      m2_prev_q <= 1'b0;
    end else begin
      m2_sync_q <= {m2_sync_q[0], m2};
      m2_prev_q <= m2_sync_q[1];
    end
  end

  assign m2_fall = m2_prev_q & ~m2_sync_q[1];

  // Sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= StIdle;
      cnt_q        <= '0;
      lat_q        <= '0;
      tmo_q        <= '0;
      sig_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sst_act_q    <= 1'b0;
      sst_we_q     <= 1'b0;
      sst_addr_q   <= '0;
      sst_dato_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (start_save || start_load) begin
            busy_q    <= 1'b1;
            sst_act_q <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            if (start_save) begin
              st_q <= StRdSet;
            end else begin
              din_ready_q <= 1'b1;
              st_q        <= (CntSig == 9'd0) ? StLdSig : StLdGet;
            end
          end
        end
        StRdSet: begin
          sst_addr_q <= cnt_q[7:0];
          lat_q      <= '0;
          st_q       <= StRdWait;
        end
        StRdWait: begin
          // Readback is valid on the RD_LAT-th edge after the address change.
          if (lat_q == LatLast) begin
            dout_q       <= sst_di;
            dout_valid_q <= 1'b1;
            st_q         <= StRdPush;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StRdPush: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            cnt_q        <= cnt_q + 9'd1;
            if (cnt_q == CntLast) begin
              done_q <= 1'b1;
              st_q   <= StFin;
            end else begin
              st_q <= StRdSet;
            end
          end
        end
        StLdGet: begin
          if (din_valid) begin
            sst_dato_q  <= din;
            sst_addr_q  <= cnt_q[7:0];
            din_ready_q <= 1'b0;
            sst_we_q    <= 1'b1;
            tmo_q       <= '0;
            st_q        <= StLdArm;
          end
        end
        StLdArm: begin
          if (m2_fall) begin
            st_q <= StLdHold;
          end else if (tmo_q == TmoLast) begin
            err_q    <= 1'b1;
            sst_we_q <= 1'b0;
            done_q   <= 1'b1;
            st_q     <= StFin;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StLdHold: begin
          // One extra cycle of strobe covers skew between raw and synchronized M2.
          sst_we_q    <= 1'b0;
          cnt_q       <= cnt_q + 9'd1;
          din_ready_q <= 1'b1;
          st_q        <= (cnt_q == CntSig) ? StLdSig : StLdGet;
        end
        StLdSig: begin
          if (din_valid) begin
            sig_q       <= din;
            sst_addr_q  <= SigAddr;
            din_ready_q <= 1'b0;
            lat_q       <= '0;
            st_q        <= StLdSigWait;
          end
        end
        StLdSigWait: begin
          if (lat_q == LatLast) begin
            if (sst_di != sig_q) err_q <= 1'b1;
            done_q <= 1'b1;
            st_q   <= StFin;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StFin: begin
          busy_q    <= 1'b0;
          sst_act_q <= 1'b0;
          st_q      <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sst_act    = sst_act_q;
  assign sst_addr   = sst_addr_q;
  assign sst_we_reg = sst_we_q;
  assign sst_dato   = sst_dato_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign din_ready  = din_ready_q;

endmodule

// File: tb/tb_sst_reg_dumper.sv
// Directed bench for sst_reg_dumper with a behavioural mapper model on the save-state bus.
module tb_sst_reg_dumper;

  localparam int unsigned RegCount  = 128;
  localparam int unsigned RdLat     = 2;
  localparam int unsigned M2Timeout = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m2 = 1'b1;
  logic       start_save = 1'b0;
  logic       start_load = 1'b0;
  logic       busy, done, err, sst_act, sst_we_reg;
  logic [7:0] sst_addr, sst_dato, sst_di, dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;

  sst_reg_dumper #(
    .REG_COUNT (RegCount),
    .RD_LAT    (RdLat),
    .M2_TIMEOUT(M2Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m2        (m2),
    .start_save(start_save),
    .start_load(start_load),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sst_act   (sst_act),
    .sst_addr  (sst_addr),
    .sst_we_reg(sst_we_reg),
    .sst_dato  (sst_dato),
    .sst_di    (sst_di),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready)
  );

  always #5 clk = ~clk;

  // M2 generator: period 12 clk when enabled, held high otherwise.
  logic m2_en = 1'b0;
  int   m2_div = 0;
  always @(posedge clk) begin
    if (m2_en) begin
      if (m2_div == 5) begin
        m2_div <= 0;
        m2     <= ~m2;
      end else begin
        m2_div <= m2_div + 1;
      end
    end else begin
      m2     <= 1'b1;
      m2_div <= 0;
    end
  end

  // Mapper model: registers latch on the raw M2 fall while the strobe is high;
  // readback is valid by the RD_LAT-th edge after an address change.
  logic [7:0] regs [256];
  logic [7:0] di_q;
  logic       m2_seen_q = 1'b1;
  logic       we_seen_q = 1'b0;
  int         falls_in_pulse = 0;
  int         we_pulses = 0;
  int         we_nofall = 0;
  logic       init_req = 1'b0;
  int         init_mode = 0;

  always @(posedge clk) begin
    m2_seen_q <= m2;
    we_seen_q <= sst_we_reg;
    if (init_req) begin
      for (int a = 0; a < 256; a++) begin
        if (init_mode == 1) regs[a] <= 8'(a) ^ 8'h5A;
        else regs[a] <= 8'h00;
      end
      regs[RegCount-1] <= 8'h20;
    end else if (m2_seen_q && !m2 && sst_act && sst_we_reg) begin
      regs[sst_addr] <= sst_dato;
      falls_in_pulse <= falls_in_pulse + 1;
    end
    if (we_seen_q && !sst_we_reg) begin
      we_pulses <= we_pulses + 1;
      if (falls_in_pulse == 0) we_nofall <= we_nofall + 1;
      falls_in_pulse <= 0;
    end
    di_q <= regs[sst_addr];
  end
  assign sst_di = di_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream bookkeeping shared by the run task.
  logic [7:0]  src [256];
  int          n_src = 0;
  int          src_idx = 0;
  logic [7:0]  rx [256];
  int          n_rx = 0;
  bit          rdy_rand = 0;
  logic [15:0] lfsr = 16'hACE1;
  int          stab_viol = 0;
  int          done_cnt = 0;
  logic        we_at_done = 1'b0;

  task automatic preset(input int mode);
    @(negedge clk);
    init_mode = mode;
    init_req  = 1'b1;
    @(negedge clk);
    init_req  = 1'b0;
  endtask

  task automatic pulse_start(input bit save, input bit sync_m2);
    src_idx = 0;
    n_rx    = 0;
    if (sync_m2) @(posedge m2);
    @(negedge clk);
    start_save = save;
    start_load = !save;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  // Drives both streams each negedge until done or the cycle bound expires.
  task automatic run_op(input int bound, output int cyc);
    bit         pend;
    bit         hold;
    logic [7:0] prev;
    cyc = 0; done_cnt = 0; pend = 0; hold = 0; prev = 8'h00;
    forever begin
      if (pend) src_idx++;
      din       = src[src_idx];
      din_valid = (src_idx < n_src);
      pend      = din_valid && din_ready;
      if (rdy_rand) begin
        lfsr       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        dout_ready = lfsr[0];
      end else begin
        dout_ready = 1'b1;
      end
      if (hold && (!dout_valid || dout != prev)) stab_viol++;
      if (dout_valid && dout_ready && n_rx < 256) begin
        rx[n_rx] = dout;
        n_rx++;
      end
      hold = dout_valid && !dout_ready;
      prev = dout;
      if (done) begin
        done_cnt++;
        we_at_done = sst_we_reg;
        break;
      end
      @(negedge clk);
      cyc++;
      if (cyc > bound) begin
        check_eq("op_bound_done", 32'(done), 32'd1);
        break;
      end
    end
    if (pend) src_idx++;
    din_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  function automatic logic [7:0] save_exp(input int a);
    return (a == RegCount - 1) ? 8'h20 : (8'(a) ^ 8'h5A);
  endfunction

  task automatic check_save_image(input string tag);
    int bad = 0;
    for (int i = 0; i < RegCount; i++) if (rx[i] !== save_exp(i)) bad++;
    check_eq({tag, "_count"}, n_rx, RegCount);
    check_eq({tag, "_bad_bytes"}, bad, 0);
    check_eq({tag, "_byte0"}, {24'd0, rx[0]}, 32'h5A);
    check_eq({tag, "_byte1"}, {24'd0, rx[1]}, 32'h5B);
    check_eq({tag, "_byte127"}, {24'd0, rx[RegCount-1]}, 32'h20);
  endtask

  task automatic check_load_regs(input string tag);
    int bad = 0;
    for (int a = 0; a < RegCount - 1; a++) if (regs[a] !== 8'(8'h80 + a)) bad++;
    check_eq({tag, "_bad_regs"}, bad, 0);
    check_eq({tag, "_sig_reg"}, {24'd0, regs[RegCount-1]}, 32'h20);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int p0, nf0, dn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_ctrl", {25'd0, busy, done, err, sst_act, sst_we_reg, dout_valid, din_ready}, 0);
    check_eq("reset_data", {8'd0, sst_addr, sst_dato, dout}, 0);

    // 1: SAVE with ready held high.
    preset(1);
    rdy_rand = 0; stab_viol = 0; n_src = 0;
    pulse_start(1'b1, 1'b0);
    check_eq("save1_busy", 32'(busy), 1);
    run_op(3000, cyc);
    check_save_image("save1");
    check_eq("save1_cycles", cyc, 512);
    check_eq("save1_done", done_cnt, 1);
    check_eq("save1_err", 32'(err), 0);
    check_eq("save1_idle", {30'd0, busy, sst_act}, 0);

    // 2: SAVE with pseudo-random ready.
    rdy_rand = 1; stab_viol = 0;
    pulse_start(1'b1, 1'b0);
    run_op(6000, cyc);
    rdy_rand = 0;
    check_save_image("save2");
    check_eq("save2_stable", stab_viol, 0);
    check_eq("save2_done", done_cnt, 1);

    // 3: LOAD with matching signature, M2 period 12.
    preset(2);
    for (int a = 0; a < RegCount - 1; a++) src[a] = 8'(8'h80 + a);
    src[RegCount-1] = 8'h20;
    n_src = RegCount;
    m2_en = 1'b1;
    p0 = we_pulses; nf0 = we_nofall;
    pulse_start(1'b0, 1'b1);
    run_op(5000, cyc);
    check_load_regs("load3");
    check_eq("load3_consumed", src_idx, RegCount);
    check_eq("load3_we_pulses", we_pulses - p0, RegCount - 1);
    check_eq("load3_we_nofall", we_nofall - nf0, 0);
    check_eq("load3_err", 32'(err), 0);
    check_eq("load3_done", done_cnt, 1);

    // 4: LOAD with wrong signature byte.
    preset(2);
    src[RegCount-1] = 8'h21;
    p0 = we_pulses;
    pulse_start(1'b0, 1'b1);
    run_op(5000, cyc);
    check_load_regs("load4");
    check_eq("load4_we_pulses", we_pulses - p0, RegCount - 1);
    check_eq("load4_err", 32'(err), 1);
    check_eq("load4_done", done_cnt, 1);
    repeat (5) @(negedge clk);
    check_eq("load4_err_sticky", 32'(err), 1);

    // 5: LOAD with M2 held high hits the timeout.
    m2_en = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start(1'b0, 1'b0);
    check_eq("load5_err_cleared", 32'(err), 0);
    run_op(3000, cyc);
    check_eq("load5_cycles", cyc, M2Timeout + 1);
    check_eq("load5_done", done_cnt, 1);
    check_eq("load5_err", 32'(err), 1);
    check_eq("load5_we_at_done", 32'(we_at_done), 0);
    check_eq("load5_act", {30'd0, sst_act, sst_we_reg}, 0);
    check_eq("load5_consumed", src_idx, 1);

    // 6: reset in the middle of a SAVE, then a clean restart.
    preset(1);
    dout_ready = 1'b1;
    pulse_start(1'b1, 1'b0);
    cyc = 0;
    while (sst_addr != 8'd40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst6_reached_addr", {24'd0, sst_addr}, 40);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst6_ctrl", {25'd0, busy, done, err, sst_act, sst_we_reg, dout_valid, din_ready}, 0);
    check_eq("rst6_data", {8'd0, sst_addr, sst_dato, dout}, 0);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check_eq("rst6_quiet", dn, 0);
    pulse_start(1'b1, 1'b0);
    check_eq("rst6_restart_addr", {24'd0, sst_addr}, 0);
    run_op(3000, cyc);
    check_save_image("rst6_save");
    check_eq("rst6_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
